ccr_unit: RTL and testbench
===========================

# ccr_unit

Condition-code register stage directly downstream of the execute-stage ALU. Latches the ALU's zero/sign/carry outputs under a per-flag write mask, applies SETC/CLRC, evaluates conditional jumps against the registered flags, and clears the tested flag when a jump is taken. Saves flags on interrupt entry and restores them on RTI through a small nesting stack, so interrupt service routines cannot corrupt the interrupted code's flags.

## Interface
- NEST_DEPTH, 4, number of flag-stack entries (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_flags  in  6  ALU flag outputs; bit0 Z, bit1 N, bit2 C, bits 5:3 ignored
- flag_wr  in  3  per-flag write mask; bit0 Z, bit1 N, bit2 C
- set_c  in  1  SETC in execute
- clr_c  in  1  CLRC in execute
- br_op  in  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JMP, others treated as none
- stall  in  1  freezes all state
- int_save  in  1  interrupt entry; push flags
- rti_restore  in  1  RTI; pop flags
- ccr  out  3  registered flags {C,N,Z}
- br_taken  out  1  combinational jump decision
- depth  out  $clog2(NEST_DEPTH+1)  current stack occupancy
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty

## Operation
- br_taken = (JMP) | (JZ & ccr[0]) | (JN & ccr[1]) | (JC & ccr[2]). It uses the registered ccr and is never forced low by stall.
- Next-flag computation, in increasing priority:
  - Taken JZ/JN/JC clears its tested flag.
  - ALU write: each bit with flag_wr=1 takes alu_flags.
  - clr_c clears C.
  - set_c sets C. set_c wins over clr_c.
- Per-cycle priority:
  - rst: ccr, depth, and the err bits clear; stack contents are don't-care.
  - stall: nothing changes.
  - rti_restore:
    - If depth>0, ccr loads the top entry and depth decrements.
    - If depth==0, ccr clears to 000 and unf_err sets.
    - All other updates that cycle are discarded. int_save is ignored if asserted in the same cycle.
  - Normal: ccr loads the next-flag value.
    - With int_save and depth<NEST_DEPTH, that same next-flag value is pushed and depth increments.
    - With int_save when full, the push is dropped, ovf_err sets, and ccr still updates.
- ovf_err and unf_err clear only on rst.

## Timing
- ccr updates one cycle after inputs are sampled, with no bypass. A jump in the cycle after a flag-setting op sees the new flags.
- br_taken has zero latency from br_op and ccr.
- A taken-jump clear is visible in ccr one cycle later.
- Push and pop complete in one cycle. A back-to-back save→restore returns the saved value on the second edge.
- A reset asserted mid-nest discards all saved entries. depth reads 0 on the first edge with rst high.

## Configuration
- FLAG_STACK_EN defined: NEST_DEPTH-entry stack exactly as above.
- FLAG_STACK_EN undefined:
  - A single shadow register replaces the stack, and NEST_DEPTH is ignored.
  - int_save always overwrites the shadow. rti_restore always loads it.
  - depth, ovf_err and unf_err are tied to 0.

## Test plan
- Flag write mask: after rst, alu_flags=6'b000101, flag_wr=011 → next ccr=001. Then flag_wr=100 with alu_flags C=1 → ccr=101.
- Taken-jump clear: ccr=001, br_op=JZ → br_taken=1 that cycle, next ccr=000. br_op=JC with C=0 → br_taken=0 and ccr unchanged. JMP with ccr=000 → br_taken=1.
- Carry controls: set_c and clr_c asserted together with flag_wr=100 and alu C=0 → ccr[2]=1.
- Nesting: ccr=011, int_save → depth=1. Set ccr=100, int_save → depth=2. Clear flags. rti_restore twice → ccr=100 then 011, depth 2→1→0.
- Over/underflow (NEST_DEPTH=4): five int_save pulses → depth=4 and ovf_err=1. Five rti_restore pulses → ccr=000 on the fifth, unf_err=1, and both err bits stay set until rst.
- Stall and reset: stall high with all controls active → ccr and depth frozen. rst asserted at depth=3 → ccr=000, depth=0, err bits 0 on the next edge.

Source files
------------

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register stage that sits right after the execute ALU.
// It does four things:
//   - latches the ALU Z/N/C flags under a per-flag write mask
//   - applies SETC/CLRC
//   - decides conditional jumps from the registered flags, and clears the tested
//     flag when a jump is taken
//   - saves flags on interrupt entry and restores them on RTI
// Build option FLAG_STACK_EN:
//   - defined:   a NEST_DEPTH-entry flag stack with occupancy and sticky
//                overflow/underflow reporting.
//   - undefined: a single shadow register replaces the stack; depth, ovf_err and
//                unf_err read as zero.
module ccr_unit #(
    parameter int NEST_DEPTH = 4,
    localparam int DW = $clog2(NEST_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    alu_flags,
    input  logic [2:0]    flag_wr,
    input  logic          set_c,
    input  logic          clr_c,
    input  logic [2:0]    br_op,
    input  logic          stall,
    input  logic          int_save,
    input  logic          rti_restore,
    output logic [2:0]    ccr,
    output logic          br_taken,
    output logic [DW-1:0] depth,
    output logic          ovf_err,
    output logic          unf_err
);

    localparam logic [2:0] BR_JZ  = 3'b001;
    localparam logic [2:0] BR_JN  = 3'b010;
    localparam logic [2:0] BR_JC  = 3'b011;
    localparam logic [2:0] BR_JMP = 3'b100;

    logic [2:0] ccr_reg;
    logic [2:0] flag_next;

    // Only Z/N/C are architectural. The upper ALU flag bits are deliberately
    // dropped here.
    logic unused_alu_bits;
    assign unused_alu_bits = &{1'b0, alu_flags[5:3]};

    // Jump decision uses the registered flags only. Stall must not mask it,
    // because the fetch side decides what to do with a stalled redirect.
    always_comb begin
        br_taken = 1'b0;
        case (br_op)
            BR_JZ:   br_taken = ccr_reg[0];
            BR_JN:   br_taken = ccr_reg[1];
            BR_JC:   br_taken = ccr_reg[2];
            BR_JMP:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-flag value. Later assignments override earlier ones, in this order:
    // taken-jump clear, then masked ALU write, then CLRC, then SETC.
    always_comb begin
        flag_next = ccr_reg;
        if (br_taken) begin
            case (br_op)
                BR_JZ:   flag_next[0] = 1'b0;
                BR_JN:   flag_next[1] = 1'b0;
                BR_JC:   flag_next[2] = 1'b0;
                default: flag_next = ccr_reg;
            endcase
        end
        flag_next = (flag_next & ~flag_wr) | (alu_flags[2:0] & flag_wr);
        if (clr_c) flag_next[2] = 1'b0;
        if (set_c) flag_next[2] = 1'b1;
    end

    assign ccr = ccr_reg;

`ifdef FLAG_STACK_EN
    localparam int AW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(NEST_DEPTH);

    logic [2:0]    stack_mem [NEST_DEPTH];
    logic [DW-1:0] depth_reg;
    logic          ovf_reg;
    logic          unf_reg;
    logic          push_en;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    // A push is accepted only on a normal (non-RTI) cycle that has room left.
    assign push_en  = !rst && !stall && !rti_restore && int_save && (depth_reg != FULL);
    assign push_idx = depth_reg[AW-1:0];
    assign pop_idx  = AW'(depth_reg - 1'b1);

    // Stack storage. It has no reset, because its contents are meaningless
    // once depth is cleared.
    always_ff @(posedge clk) begin
        if (push_en) stack_mem[push_idx] <= flag_next;
    end

    // Flag register, stack occupancy and the sticky error bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_reg   <= '0;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (!stall) begin
            if (rti_restore) begin
                if (depth_reg != '0) begin
                    ccr_reg   <= stack_mem[pop_idx];
                    depth_reg <= depth_reg - 1'b1;
                end else begin
                    ccr_reg <= '0;
                    unf_reg <= 1'b1;
                end
            end else begin
                ccr_reg <= flag_next;
                if (int_save) begin
                    if (depth_reg != FULL) depth_reg <= depth_reg + 1'b1;
                    else                   ovf_reg   <= 1'b1;
                end
            end
        end
    end

    assign depth   = depth_reg;
    assign ovf_err = ovf_reg;
    assign unf_err = unf_reg;
`else
    logic [2:0] shadow_reg;

    // Shadow copy: every interrupt entry overwrites it. It has no reset,
    // because it only matters after a save.
    always_ff @(posedge clk) begin
        if (!rst && !stall && !rti_restore && int_save) shadow_reg <= flag_next;
    end

    // Flag register. RTI reloads the shadow and discards that cycle's other updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_reg <= '0;
        end else if (!stall) begin
            if (rti_restore) ccr_reg <= shadow_reg;
            else             ccr_reg <= flag_next;
        end
    end

    assign depth   = '0;
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit: scoreboard bench for ccr_unit.
// Stimulus flow, once per cycle:
//   - the driver applies inputs on the falling edge
//   - it advances an abstract flag/stack model
//   - it queues the expected branch decision and post-edge state
// An independent monitor samples the DUT and checks it against the queue.
// Works in either build (FLAG_STACK_EN defined or not).
module tb_ccr_unit;
    localparam int NEST_DEPTH = 4;
    localparam int DW = $clog2(NEST_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    alu_flags = '0;
    logic [2:0]    flag_wr = '0;
    logic          set_c = 1'b0;
    logic          clr_c = 1'b0;
    logic [2:0]    br_op = '0;
    logic          stall = 1'b0;
    logic          int_save = 1'b0;
    logic          rti_restore = 1'b0;
    logic [2:0]    ccr;
    logic          br_taken;
    logic [DW-1:0] depth;
    logic          ovf_err;
    logic          unf_err;

    ccr_unit #(.NEST_DEPTH(NEST_DEPTH)) dut (
        .clk(clk), .rst(rst), .alu_flags(alu_flags), .flag_wr(flag_wr),
        .set_c(set_c), .clr_c(clr_c), .br_op(br_op), .stall(stall),
        .int_save(int_save), .rti_restore(rti_restore), .ccr(ccr),
        .br_taken(br_taken), .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ccr;
        int         depth;
        logic       ovf;
        logic       unf;
        logic       br;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    txn = 0;

    // Reference model state: the flags, a LIFO of saved flag values, and the error bits.
    logic [2:0] m_ccr = '0;
    logic [2:0] m_stack[$];
    logic [2:0] m_shadow = '0;
    bit         m_shadow_valid = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    task automatic chk(input string nm, input string field, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, field, act, expv);
        end
    endtask

    // One cycle of stimulus plus the model's prediction for it.
    task automatic cyc(input bit r, input bit st, input logic [5:0] af, input logic [2:0] wr,
                       input bit sc, input bit cc, input logic [2:0] op,
                       input bit sv, input bit rt, input string nm);
        exp_t       e;
        logic [2:0] nf;
        bit         rt_eff;
        rt_eff = rt;
`ifndef FLAG_STACK_EN
        if (!m_shadow_valid) rt_eff = 0;
`endif
        @(negedge clk);
        rst = r; stall = st; alu_flags = af; flag_wr = wr; set_c = sc; clr_c = cc;
        br_op = op; int_save = sv; rti_restore = rt_eff;

        e.br = (op == 3'd4) || (op == 3'd1 && m_ccr[0]) ||
               (op == 3'd2 && m_ccr[1]) || (op == 3'd3 && m_ccr[2]);
        nf = m_ccr;
        if (e.br && op != 3'd4) nf[int'(op) - 1] = 1'b0;
        for (int i = 0; i < 3; i++) if (wr[i]) nf[i] = af[i];
        if (cc) nf[2] = 1'b0;
        if (sc) nf[2] = 1'b1;

        if (r) begin
            m_ccr = '0; m_stack.delete(); m_ovf = 0; m_unf = 0; m_shadow_valid = 0;
        end else if (!st) begin
            if (rt_eff) begin
`ifdef FLAG_STACK_EN
                if (m_stack.size() > 0) m_ccr = m_stack.pop_back();
                else begin m_ccr = '0; m_unf = 1; end
`else
                m_ccr = m_shadow;
`endif
            end else begin
                if (sv) begin
`ifdef FLAG_STACK_EN
                    if (m_stack.size() < NEST_DEPTH) m_stack.push_back(nf);
                    else m_ovf = 1;
`else
                    m_shadow = nf; m_shadow_valid = 1;
`endif
                end
                m_ccr = nf;
            end
        end
        e.ccr = m_ccr;
`ifdef FLAG_STACK_EN
        e.depth = m_stack.size();
        e.ovf = m_ovf; e.unf = m_unf;
`else
        e.depth = 0; e.ovf = 0; e.unf = 0;
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: reads br_taken mid-cycle and the registered state just after
    // the edge, then checks both against the oldest queued expectation.
    initial begin
        exp_t  e;
        string nm;
        logic  br_s;
        forever begin
            @(negedge clk);
            #2 br_s = br_taken;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                txn++;
                $display("txn %0d %s ccr=%03b depth=%0d ovf=%0b unf=%0b br=%0b",
                         txn, nm, ccr, depth, ovf_err, unf_err, br_s);
                chk(nm, "br_taken", int'(br_s), int'(e.br));
                chk(nm, "ccr", int'(ccr), int'(e.ccr));
                chk(nm, "depth", int'(depth), e.depth);
                chk(nm, "ovf_err", int'(ovf_err), int'(e.ovf));
                chk(nm, "unf_err", int'(unf_err), int'(e.unf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        cyc(1, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 0, "reset");
        cyc(1, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 0, "reset");
        // masked flag writes; upper ALU bits must be ignored
        cyc(0, 0, 6'b000101, 3'b011, 0, 0, 3'd0, 0, 0, "wr_zn");
        cyc(0, 0, 6'b111100, 3'b100, 0, 0, 3'd0, 0, 0, "wr_c");
        // taken-jump clear, untaken jump, unconditional jump
        cyc(0, 0, 6'b000001, 3'b111, 0, 0, 3'd0, 0, 0, "set_z");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd1, 0, 0, "jz_taken");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd3, 0, 0, "jc_not");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd4, 0, 0, "jmp");
        cyc(0, 0, 6'b000010, 3'b010, 0, 0, 3'd0, 0, 0, "set_n");
        cyc(0, 0, 6'b000000, 3'b000, 0, 0, 3'd2, 0, 0, "jn_taken");
        // SETC beats CLRC and the ALU write of C
        cyc(0, 0, 6'b000000, 3'b100, 1, 1, 3'd0, 0, 0, "carry_both");
        cyc(0, 0, 6'b000000, 3'b000, 0, 1, 3'd0, 0, 0, "clrc");
        // nesting
        cyc(0, 0, 6'b000011, 3'b111, 0, 0, 3'd0, 0, 0, "set_011");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 1, 0, "save1");
        cyc(0, 0, 6'b000100, 3'b111, 0, 0, 3'd0, 0, 0, "set_100");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 1, 0, "save2");
        cyc(0, 0, 6'b000000, 3'b111, 0, 0, 3'd0, 0, 0, "clear");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 1, "rti1");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 1, "rti2");
        // back-to-back save then restore; save ignored when paired with RTI
        cyc(0, 0, 6'b000110, 3'b111, 0, 0, 3'd0, 1, 0, "save_b2b");
        cyc(0, 0, 6'b000001, 3'b111, 1, 0, 3'd4, 1, 1, "rti_b2b");
        // overflow then underflow
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 6'(i + 1), 3'b111, 0, 0, 3'd0, 1, 0, "ovf_push");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 1, "unf_pop");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 0, "err_sticky");
        cyc(0, 0, 6'b000111, 3'b111, 0, 0, 3'd0, 0, 0, "err_sticky");
        // stall freezes everything but br_taken still follows br_op
        cyc(0, 1, 6'h00, 3'b111, 1, 1, 3'd4, 1, 1, "stall_all");
        cyc(0, 1, 6'h00, 3'b111, 0, 1, 3'd1, 1, 0, "stall_jz");
        // reset mid-nest
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 6'(i + 5), 3'b111, 0, 0, 3'd0, 1, 0, "nest3");
        cyc(1, 0, 6'h3f, 3'b111, 1, 0, 3'd0, 1, 0, "rst_nest");
        cyc(0, 0, 6'h00, 3'b000, 0, 0, 3'd0, 0, 1, "rti_after_rst");
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 6'($urandom), 3'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "rand");
        end
        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
